// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants for the single-clock FIFO: read-mode encodings and default thresholds.
// Every file of the FIFO imports this package.
package sync_fifo_fwft_pkg;

  localparam bit FIFO_FWFT = 1'b1;
  localparam bit FIFO_STD  = 1'b0;

  localparam int DEF_DATAWIDTH = 64;
  localparam int DEF_ASIZE     = 7;
  localparam int DEF_AFULL_TH  = 120;
  localparam int DEF_AEMPTY_TH = 8;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Both read modes of the FIFO share this storage.
module sync_fifo_mem
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ASIZE     = DEF_ASIZE
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ASIZE-1:0]     waddr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic [ASIZE-1:0]     raddr_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; occupancy is tracked entirely by the FIFO control logic.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with registered fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable FWFT or registered read port.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter bit FWFT      = FIFO_FWFT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wen,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 ren,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid,
  output logic                 wfull,
  output logic                 rempty,
  output logic                 walmost_full,
  output logic                 ralmost_empty,
  output logic [ASIZE:0]       count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int CW    = ASIZE + 1;
  localparam int DEPTH = 2 ** ASIZE;

  logic [ASIZE:0]       wptr_q, rptr_q;
  logic [ASIZE:0]       count_q, count_d;
  logic                 wfull_q, wfull_d;
  logic                 rempty_q, rempty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 wr_ok, rd_ok;
  logic [DATAWIDTH-1:0] mem_rdata;

  assign wr_ok = wen & ~wfull_q;
  assign rd_ok = ren & ~rempty_q;

  // Flags are derived from the next count so they land on the same edge as the count itself.
  always_comb begin
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    wfull_d  = (count_d == CW'(DEPTH));
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
    ovf_d    = (wen & wfull_q)  | (ovf_q & ~clr_err);
    unf_d    = (ren & rempty_q) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DATAWIDTH (DATAWIDTH),
    .ASIZE     (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (wdata),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  // FWFT shows the head straight from the array, masked to zero while nothing is stored.
  if (FWFT) begin : g_fwft
    assign rdata  = rempty_q ? '0 : mem_rdata;
    assign rvalid = ~rempty_q;
  end else begin : g_std
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 rvalid_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem_rdata;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign count         = count_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed and scoreboard-driven checks of sync_fifo_fwft in FWFT mode (default geometry)
// and in standard registered-read mode (small geometry).
module tb_sync_fifo_fwft;
  import sync_fifo_fwft_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;

  logic        wen, ren, clrErr;
  logic [63:0] wdata, rdata;
  logic        rvalid, wfull, rempty, wAlmostFull, rAlmostEmpty, overflow, underflow;
  logic [7:0]  count;

  logic        sWen, sRen, sClrErr;
  logic [7:0]  sWdata, sRdata;
  logic        sRvalid, sWfull, sRempty, sWAlmostFull, sRAlmostEmpty, sOverflow, sUnderflow;
  logic [3:0]  sCount;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(
    .DATAWIDTH (64), .ASIZE (7), .AFULL_TH (120), .AEMPTY_TH (8), .FWFT (FIFO_FWFT)
  ) dut (
    .clk (clk), .rstn (rstn), .wen (wen), .wdata (wdata), .ren (ren),
    .rdata (rdata), .rvalid (rvalid), .wfull (wfull), .rempty (rempty),
    .walmost_full (wAlmostFull), .ralmost_empty (rAlmostEmpty), .count (count),
    .overflow (overflow), .underflow (underflow), .clr_err (clrErr)
  );

  sync_fifo_fwft #(
    .DATAWIDTH (8), .ASIZE (3), .AFULL_TH (6), .AEMPTY_TH (1), .FWFT (FIFO_STD)
  ) dutStd (
    .clk (clk), .rstn (rstn), .wen (sWen), .wdata (sWdata), .ren (sRen),
    .rdata (sRdata), .rvalid (sRvalid), .wfull (sWfull), .rempty (sRempty),
    .walmost_full (sWAlmostFull), .ralmost_empty (sRAlmostEmpty), .count (sCount),
    .overflow (sOverflow), .underflow (sUnderflow), .clr_err (sClrErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wen = 0; ren = 0; clrErr = 0; wdata = '0;
    sWen = 0; sRen = 0; sClrErr = 0; sWdata = '0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    checkCount++;
    if (count !== 8'd0) begin errCount++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checkCount++;
    if ({rempty, rAlmostEmpty} !== 2'b11) begin errCount++; $display("[TB] FAIL reset_empty_flags: got %b expected 11", {rempty, rAlmostEmpty}); end
    checkCount++;
    if ({wfull, wAlmostFull, rvalid, overflow, underflow} !== 5'b0) begin
      errCount++; $display("[TB] FAIL reset_other_flags: got %b expected 00000", {wfull, wAlmostFull, rvalid, overflow, underflow});
    end
    checkCount++;
    if (rdata !== 64'd0) begin errCount++; $display("[TB] FAIL reset_rdata: got %0h expected 0", rdata); end
    checkCount++;
    if ({sRvalid, sRempty, sCount, sRdata} !== {1'b0, 1'b1, 4'd0, 8'd0}) begin
      errCount++; $display("[TB] FAIL reset_std: got rvalid=%b rempty=%b count=%0d rdata=%0h expected 0 1 0 0", sRvalid, sRempty, sCount, sRdata);
    end
  endtask

  task automatic test_first_word();
    wen = 1; wdata = 64'hA5;
    tick();
    wen = 0;
    checkCount++;
    if ({rempty, rvalid, count} !== {1'b0, 1'b1, 8'd1}) begin
      errCount++; $display("[TB] FAIL first_word_flags: got rempty=%b rvalid=%b count=%0d expected 0 1 1", rempty, rvalid, count);
    end
    checkCount++;
    if (rdata !== 64'hA5) begin errCount++; $display("[TB] FAIL first_word_rdata: got %0h expected a5", rdata); end
    ren = 1;
    tick();
    ren = 0;
    checkCount++;
    if ({rempty, rvalid, count} !== {1'b1, 1'b0, 8'd0}) begin
      errCount++; $display("[TB] FAIL first_word_pop: got rempty=%b rvalid=%b count=%0d expected 1 0 0", rempty, rvalid, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 128; i++) begin
      wen = 1; wdata = 64'(i);
      tick();
      checkCount++;
      if (count !== 8'(i + 1)) begin errCount++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checkCount++;
      if (wAlmostFull !== (i + 1 >= 120)) begin errCount++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", i, wAlmostFull, (i + 1 >= 120)); end
      checkCount++;
      if (rAlmostEmpty !== (i + 1 <= 8)) begin errCount++; $display("[TB] FAIL fill_aempty[%0d]: got %b expected %b", i, rAlmostEmpty, (i + 1 <= 8)); end
    end
    wen = 0;
    checkCount++;
    if ({wfull, overflow} !== 2'b10) begin errCount++; $display("[TB] FAIL fill_full: got wfull=%b overflow=%b expected 1 0", wfull, overflow); end
    checkCount++;
    if (rdata !== 64'd0) begin errCount++; $display("[TB] FAIL fill_head: got %0h expected 0", rdata); end
    wen = 1; wdata = 64'hDEAD;
    tick();
    wen = 0;
    checkCount++;
    if ({count, wfull, overflow} !== {8'd128, 1'b1, 1'b1}) begin
      errCount++; $display("[TB] FAIL fill_overflow: got count=%0d wfull=%b overflow=%b expected 128 1 1", count, wfull, overflow);
    end
  endtask

  task automatic test_full_both();
    wen = 1; ren = 1; wdata = 64'hBAD;
    tick();
    wen = 0; ren = 0;
    checkCount++;
    if ({count, wfull, overflow, wAlmostFull} !== {8'd127, 1'b0, 1'b1, 1'b1}) begin
      errCount++; $display("[TB] FAIL full_both_flags: got count=%0d wfull=%b overflow=%b afull=%b expected 127 0 1 1", count, wfull, overflow, wAlmostFull);
    end
    checkCount++;
    if (rdata !== 64'd1) begin errCount++; $display("[TB] FAIL full_both_head: got %0h expected 1", rdata); end
  endtask

  task automatic test_drain_and_errors();
    for (int i = 1; i < 128; i++) begin
      checkCount++;
      if (rdata !== 64'(i)) begin errCount++; $display("[TB] FAIL drain_data[%0d]: got %0h expected %0h", i, rdata, i); end
      ren = 1;
      tick();
      checkCount++;
      if (count !== 8'(127 - i)) begin errCount++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", i, count, 127 - i); end
      checkCount++;
      if (rAlmostEmpty !== (127 - i <= 8)) begin errCount++; $display("[TB] FAIL drain_aempty[%0d]: got %b expected %b", i, rAlmostEmpty, (127 - i <= 8)); end
    end
    checkCount++;
    if ({rempty, rvalid, underflow} !== 3'b100) begin
      errCount++; $display("[TB] FAIL drain_empty: got rempty=%b rvalid=%b underflow=%b expected 1 0 0", rempty, rvalid, underflow);
    end
    tick();
    ren = 0;
    checkCount++;
    if ({underflow, count} !== {1'b1, 8'd0}) begin
      errCount++; $display("[TB] FAIL underflow_set: got underflow=%b count=%0d expected 1 0", underflow, count);
    end
    ren = 1; clrErr = 1;
    tick();
    ren = 0;
    checkCount++;
    if (underflow !== 1'b1) begin errCount++; $display("[TB] FAIL set_beats_clear: got %b expected 1", underflow); end
    tick();
    clrErr = 0;
    checkCount++;
    if ({overflow, underflow} !== 2'b00) begin errCount++; $display("[TB] FAIL clr_err: got %b expected 00", {overflow, underflow}); end
    wen = 1; ren = 1; wdata = 64'h77;
    tick();
    wen = 0; ren = 0;
    checkCount++;
    if ({count, underflow, rempty} !== {8'd1, 1'b1, 1'b0}) begin
      errCount++; $display("[TB] FAIL empty_both_flags: got count=%0d underflow=%b rempty=%b expected 1 1 0", count, underflow, rempty);
    end
    checkCount++;
    if (rdata !== 64'h77) begin errCount++; $display("[TB] FAIL empty_both_head: got %0h expected 77", rdata); end
    clrErr = 1; ren = 1;
    tick();
    clrErr = 0; ren = 0;
    checkCount++;
    if ({count, underflow} !== {8'd0, 1'b0}) begin
      errCount++; $display("[TB] FAIL empty_both_pop: got count=%0d underflow=%b expected 0 0", count, underflow);
    end
  endtask

  task automatic test_std_mode();
    sWen = 1; sWdata = 8'h11;
    tick();
    sWdata = 8'h22;
    tick();
    sWen = 0;
    checkCount++;
    if ({sRvalid, sCount} !== {1'b0, 4'd2}) begin errCount++; $display("[TB] FAIL std_idle: got rvalid=%b count=%0d expected 0 2", sRvalid, sCount); end
    sRen = 1;
    tick();
    sRen = 0;
    checkCount++;
    if ({sRvalid, sRdata} !== {1'b1, 8'h11}) begin errCount++; $display("[TB] FAIL std_read1: got rvalid=%b rdata=%0h expected 1 11", sRvalid, sRdata); end
    tick();
    checkCount++;
    if ({sRvalid, sRdata} !== {1'b0, 8'h11}) begin errCount++; $display("[TB] FAIL std_hold: got rvalid=%b rdata=%0h expected 0 11", sRvalid, sRdata); end
    sRen = 1;
    tick();
    sRen = 0;
    checkCount++;
    if ({sRvalid, sRdata, sCount} !== {1'b1, 8'h22, 4'd0}) begin
      errCount++; $display("[TB] FAIL std_read2: got rvalid=%b rdata=%0h count=%0d expected 1 22 0", sRvalid, sRdata, sCount);
    end
    tick();
    checkCount++;
    if (sRvalid !== 1'b0) begin errCount++; $display("[TB] FAIL std_pulse_end: got %b expected 0", sRvalid); end
  endtask

  task automatic test_stream();
    logic [63:0] model[$];
    int          written = 0;
    int          cycles  = 0;
    logic        expWr, expRd;
    while ((written < 1000 || model.size() > 0) && cycles < 20000) begin
      wen   = (written < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ren   = (written < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata = {32'h5EED_0000, 32'(written)};
      expWr = wen && (model.size() < 128);
      expRd = ren && (model.size() > 0);
      if (expRd) begin
        checkCount++;
        if (rdata !== model[0]) begin errCount++; $display("[TB] FAIL stream_data: got %0h expected %0h", rdata, model[0]); end
      end
      tick();
      if (expRd) void'(model.pop_front());
      if (expWr) begin
        model.push_back(wdata);
        written++;
      end
      checkCount++;
      if (count !== 8'(model.size())) begin errCount++; $display("[TB] FAIL stream_count: got %0d expected %0d", count, model.size()); end
      cycles++;
    end
    wen = 0; ren = 0;
    checkCount++;
    if (written < 1000 || model.size() != 0) begin
      errCount++; $display("[TB] FAIL stream_timeout: got written=%0d left=%0d expected 1000 0", written, model.size());
    end
    wen = 1; wdata = 64'h1234;
    tick(); tick(); tick();
    wen = 0;
    #2 rstn = 1'b0;
    #1;
    checkCount++;
    if ({count, rempty, rvalid} !== {8'd0, 1'b1, 1'b0}) begin
      errCount++; $display("[TB] FAIL async_reset: got count=%0d rempty=%b rvalid=%b expected 0 1 0", count, rempty, rvalid);
    end
    tick();
    rstn = 1'b1;
    tick();
    checkCount++;
    if ({count, rempty} !== {8'd0, 1'b1}) begin errCount++; $display("[TB] FAIL after_reset: got count=%0d rempty=%b expected 0 1", count, rempty); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill();
    test_full_both();
    test_drain_and_errors();
    test_std_mode();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
